// File: rtl/updown_mod_counter_if.sv
// Command/status bundle for updown_mod_counter.
// roll_cnt is present only when UDMC_ROLLCNT_EN is defined.
interface updown_mod_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
`ifdef UDMC_ROLLCNT_EN
  ,
  parameter int ROLL_W = 8
`endif
);
  logic              en;
  logic              load;
  logic              up;
  logic              down;
  logic              sat;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  max_val;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_zero;
  logic              rollover;
  logic              rollunder;
  logic              err;
`ifdef UDMC_ROLLCNT_EN
  logic [ROLL_W-1:0] roll_cnt;
`endif

  modport master (
    output en, load, up, down, sat, step, data, max_val,
`ifdef UDMC_ROLLCNT_EN
    input  roll_cnt,
`endif
    input  count, at_max, at_zero, rollover, rollunder, err
  );

  modport slave (
    input  en, load, up, down, sat, step, data, max_val,
`ifdef UDMC_ROLLCNT_EN
    output roll_cnt,
`endif
    output count, at_max, at_zero, rollover, rollunder, err
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus and step, wrap or saturate mode.
// Define UDMC_ROLLCNT_EN to add the saturating roll_cnt event counter.
module updown_mod_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int ROLL_W = 8
) (
  input  logic                 clk,
  input  logic                 srst_n,
  updown_mod_counter_if.slave  bus
);

  if (STEP_W > WIDTH || STEP_W < 1 || ROLL_W < 1) begin : g_bad_params
    $error("updown_mod_counter: need 1 <= STEP_W <= WIDTH and ROLL_W >= 1");
  end

  logic [WIDTH-1:0] count_reg, count_next;
  logic             rollover_reg, rollover_next;
  logic             rollunder_reg, rollunder_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] step_w;
  logic [WIDTH:0]   max_ext;
  logic [WIDTH:0]   mod_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] wrap_up_w;
  logic [WIDTH-1:0] wrap_dn_w;
  logic             out_of_range;
  logic             move_req;
  logic             step_too_big;

  // All modulus arithmetic is one bit wider so max_val = all-ones (modulus 2^WIDTH) works.
  assign step_w       = WIDTH'(bus.step);
  assign max_ext      = {1'b0, bus.max_val};
  assign mod_w        = max_ext + (WIDTH+1)'(1);
  assign sum_w        = {1'b0, count_reg} + {1'b0, step_w};
  assign wrap_up_w    = WIDTH'(sum_w - mod_w);
  assign wrap_dn_w    = WIDTH'({1'b0, count_reg} + mod_w - {1'b0, step_w});
  assign out_of_range = (count_reg > bus.max_val);
  assign move_req     = (bus.up ^ bus.down) && (bus.step != '0);
  assign step_too_big = (step_w > bus.max_val);

  always_comb begin
    count_next     = count_reg;
    rollover_next  = 1'b0;
    rollunder_next = 1'b0;
    err_next       = 1'b0;
    if (bus.en) begin
      if (bus.load) begin
        if (bus.data > bus.max_val) begin
          count_next = bus.max_val;
          err_next   = 1'b1;
        end else begin
          count_next = bus.data;
        end
      end else if (out_of_range) begin
        // max_val was lowered under the count: pull it back before honouring any move.
        count_next = bus.max_val;
        err_next   = 1'b1;
      end else if (move_req) begin
        if (step_too_big) begin
          err_next = 1'b1;
        end else if (bus.up) begin
          if (sum_w > max_ext) begin
            rollover_next = 1'b1;
            count_next    = bus.sat ? bus.max_val : wrap_up_w;
          end else begin
            count_next = sum_w[WIDTH-1:0];
          end
        end else begin
          if (count_reg < step_w) begin
            rollunder_next = 1'b1;
            count_next     = bus.sat ? '0 : wrap_dn_w;
          end else begin
            count_next = count_reg - step_w;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      count_reg     <= '0;
      rollover_reg  <= 1'b0;
      rollunder_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      count_reg     <= count_next;
      rollover_reg  <= rollover_next;
      rollunder_reg <= rollunder_next;
      err_reg       <= err_next;
    end
  end

  assign bus.count     = count_reg;
  assign bus.at_max    = (count_reg == bus.max_val);
  assign bus.at_zero   = (count_reg == '0);
  assign bus.rollover  = rollover_reg;
  assign bus.rollunder = rollunder_reg;
  assign bus.err       = err_reg;

`ifdef UDMC_ROLLCNT_EN
  logic [ROLL_W-1:0] roll_cnt_reg, roll_cnt_next;

  // Counts the same edges that raise a roll pulse, so it tracks the pulses one-for-one.
  always_comb begin
    roll_cnt_next = roll_cnt_reg;
    if (bus.en && bus.load) begin
      roll_cnt_next = '0;
    end else if ((rollover_next || rollunder_next) && (roll_cnt_reg != '1)) begin
      roll_cnt_next = roll_cnt_reg + ROLL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      roll_cnt_reg <= '0;
    end else begin
      roll_cnt_reg <= roll_cnt_next;
    end
  end

  assign bus.roll_cnt = roll_cnt_reg;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed scoreboard bench for updown_mod_counter; roll_cnt is also checked
// when UDMC_ROLLCNT_EN is defined.
module tb_updown_mod_counter;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int ROLL_W = 8;

  logic clk = 1'b0;
  logic srst_n;
  always #5 clk = ~clk;

`ifdef UDMC_ROLLCNT_EN
  updown_mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .ROLL_W(ROLL_W)) bus ();
`else
  updown_mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();
`endif

  updown_mod_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .ROLL_W(ROLL_W)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0]  count;
    logic              ro;
    logic              ru;
    logic              er;
`ifdef UDMC_ROLLCNT_EN
    logic [ROLL_W-1:0] rc;
`endif
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_count = 0;
`ifdef UDMC_ROLLCNT_EN
  int   m_roll = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic load, input logic up, input logic down,
                       input logic sat, input int step, input int data, input int max_val);
    bus.en      = en;
    bus.load    = load;
    bus.up      = up;
    bus.down    = down;
    bus.sat     = sat;
    bus.step    = STEP_W'(step);
    bus.data    = WIDTH'(data);
    bus.max_val = WIDTH'(max_val);
  endtask

  // Reference behaviour in plain integer arithmetic; modulus handled with %.
  task automatic model_push();
    exp_t e;
    int c, mx, s, d;
    c  = m_count;
    mx = int'(bus.max_val);
    s  = int'(bus.step);
    d  = int'(bus.data);
    e  = '0;
    if (bus.en) begin
      if (bus.load) begin
        if (d > mx) begin
          c    = mx;
          e.er = 1'b1;
        end else begin
          c = d;
        end
      end else if (c > mx) begin
        c    = mx;
        e.er = 1'b1;
      end else if (bus.up && bus.down) begin
        c = m_count;
      end else if ((bus.up || bus.down) && s != 0) begin
        if (s > mx) begin
          e.er = 1'b1;
        end else if (bus.up) begin
          if (c + s > mx) begin
            e.ro = 1'b1;
            c    = bus.sat ? mx : (c + s) % (mx + 1);
          end else begin
            c = c + s;
          end
        end else begin
          if (s > c) begin
            e.ru = 1'b1;
            c    = bus.sat ? 0 : (c - s + mx + 1) % (mx + 1);
          end else begin
            c = c - s;
          end
        end
      end
    end
    m_count = c;
    e.count = c[WIDTH-1:0];
`ifdef UDMC_ROLLCNT_EN
    if (bus.en && bus.load) m_roll = 0;
    else if ((e.ro || e.ru) && m_roll < (1 << ROLL_W) - 1) m_roll++;
    e.rc = m_roll[ROLL_W-1:0];
`endif
    sb_q.push_back(e);
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("%s: count=%0d ro=%0b ru=%0b err=%0b at_max=%0b at_zero=%0b",
             tag, bus.count, bus.rollover, bus.rollunder, bus.err, bus.at_max, bus.at_zero);
    chk({tag, ".count"},     bus.count,     e.count);
    chk({tag, ".rollover"},  bus.rollover,  e.ro);
    chk({tag, ".rollunder"}, bus.rollunder, e.ru);
    chk({tag, ".err"},       bus.err,       e.er);
    chk({tag, ".at_max"},    bus.at_max,    e.count == bus.max_val);
    chk({tag, ".at_zero"},   bus.at_zero,   e.count == '0);
`ifdef UDMC_ROLLCNT_EN
    chk({tag, ".roll_cnt"},  bus.roll_cnt,  e.rc);
`endif
  endtask

  initial begin
    srst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 9);
    repeat (2) @(posedge clk);
    #1;
    $display("reset: count=%0d ro=%0b ru=%0b err=%0b", bus.count, bus.rollover, bus.rollunder, bus.err);
    chk("reset.count", bus.count, 0);
    chk("reset.pulses", {bus.rollover, bus.rollunder, bus.err}, 3'b000);
    chk("reset.at_zero", bus.at_zero, 1);
    srst_n = 1'b1;

    // Wrap at max 9, step 1: three wraps over 30 cycles.
    drive(1, 0, 1, 0, 0, 1, 0, 9);
    for (int i = 0; i < 30; i++) begin
      cycle($sformatf("s1.up%0d", i));
      if (i == 8) chk("s1.at_max9", {bus.count, bus.at_max}, {8'd9, 1'b1});
      if (i == 9) chk("s1.wrap0", {bus.count, bus.rollover}, {8'd0, 1'b1});
      if (i == 10) chk("s1.after_wrap", {bus.count, bus.rollover}, {8'd1, 1'b0});
    end
`ifdef UDMC_ROLLCNT_EN
    chk("s6.roll_cnt3", bus.roll_cnt, 3);
`endif

    // en=0 holds everything, load ignored.
    drive(0, 1, 1, 0, 0, 1, 3, 9);
    cycle("en0.hold");

    // Saturating down from 2 with step 3.
    drive(1, 1, 0, 0, 1, 3, 2, 20);
    cycle("s2.load2");
    drive(1, 0, 0, 1, 1, 3, 0, 20);
    cycle("s2.down0");
    cycle("s2.down1");
    chk("s2.sat_zero", {bus.count, bus.rollunder, bus.err}, {8'd0, 1'b1, 1'b0});

    // Load clamp, then in-range load.
    drive(1, 1, 0, 0, 0, 1, 'hAA, 'h7F);
    cycle("s3.loadAA");
    chk("s3.clamp", {bus.count, bus.err}, {8'h7F, 1'b1});
`ifdef UDMC_ROLLCNT_EN
    chk("s6.roll_clr", bus.roll_cnt, 0);
`endif
    drive(1, 1, 0, 0, 0, 1, 'h55, 'h7F);
    cycle("s3.load55");

    // up+down hold, oversize step.
    drive(1, 1, 0, 0, 0, 1, 5, 9);
    cycle("s4.load5");
    drive(1, 0, 1, 1, 0, 1, 0, 9);
    cycle("s4.updown");
    drive(1, 0, 1, 0, 0, 12, 0, 9);
    cycle("s4.step12");
    chk("s4.bigstep", {bus.count, bus.err, bus.rollover}, {8'd5, 1'b1, 1'b0});

    // Wrap down, full-range wrap, saturate up, max_val zero.
    drive(1, 1, 0, 0, 0, 3, 1, 9);
    cycle("wd.load1");
    drive(1, 0, 0, 1, 0, 3, 0, 9);
    cycle("wd.down3");
    drive(1, 1, 0, 0, 0, 3, 'hFE, 'hFF);
    cycle("ff.loadFE");
    drive(1, 0, 1, 0, 0, 3, 0, 'hFF);
    cycle("ff.up3");
    drive(1, 1, 0, 0, 1, 2, 9, 9);
    cycle("su.load9");
    drive(1, 0, 1, 0, 1, 2, 0, 9);
    cycle("su.up0");
    cycle("su.up1");
    drive(1, 1, 0, 0, 0, 1, 0, 0);
    cycle("z.load0");
    drive(1, 0, 1, 0, 0, 1, 0, 0);
    cycle("z.up1");
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    cycle("z.step0");

    // Asynchronous reset between edges.
    drive(1, 1, 0, 0, 0, 1, 6, 9);
    cycle("s5.load6");
    drive(1, 0, 1, 0, 0, 1, 0, 9);
    cycle("s5.up7");
    #2;
    srst_n = 1'b0;
    #1;
    $display("s5.async: count=%0d", bus.count);
    chk("s5.async_count", bus.count, 0);
    chk("s5.async_pulses", {bus.rollover, bus.rollunder, bus.err}, 3'b000);
    m_count = 0;
`ifdef UDMC_ROLLCNT_EN
    m_roll = 0;
`endif
    #2;
    srst_n = 1'b1;
    cycle("s5.resume1");
    cycle("s5.resume2");

    // max_val lowered under the count.
    drive(1, 1, 0, 0, 0, 1, 15, 20);
    cycle("s6.load15");
    drive(1, 0, 1, 0, 0, 1, 0, 10);
    cycle("s6.fix");
    chk("s6.fixed", {bus.count, bus.err, bus.rollover}, {8'd10, 1'b1, 1'b0});
    cycle("s6.wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
